// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel countdown timer.
// Holds the channel mode encoding and the default geometry.
package timer_pkg;

   typedef enum logic {
      MODE_ONESHOT  = 1'b0,
      MODE_PERIODIC = 1'b1
   } mode_e;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_CHANNELS = 4;

   // Index width for n channels, never narrower than one bit
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multi_timer_if.sv
// Control/status bundle between a timer user (master) and multi_timer (slave).
// Carries the single-channel load request, the stop mask and per-channel status.
interface multi_timer_if
   import timer_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int CH_W     = ch_idx_w(DEF_CHANNELS)
);

   logic                load;
   logic [CH_W-1:0]     load_ch;
   logic [WIDTH-1:0]    load_cycles;
   logic                load_periodic;
   logic [CHANNELS-1:0] stop;
   logic [CHANNELS-1:0] busy;
   logic [CHANNELS-1:0] expired;
   logic                any_busy;

   modport master (
      output load, load_ch, load_cycles, load_periodic, stop,
      input  busy, expired, any_busy
   );

   modport slave (
      input  load, load_ch, load_cycles, load_periodic, stop,
      output busy, expired, any_busy
   );

endinterface

// File: rtl/multi_timer_channel.sv
// One countdown channel: counter, reload value and mode, with a registered
// one-cycle expiry pulse. Priority per edge is reset > stop > load > count.
module timer_channel
   import timer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_cycles,
   input  logic             i_periodic,
   input  logic             i_stop,
   output logic             o_busy,
   output logic             o_expired
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_reload;
   mode_e            r_mode;
   logic             r_expired;

   logic [WIDTH-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_reload_nxt;
   mode_e            w_mode_nxt;
   logic             w_expired_nxt;

   always_comb begin
      w_cnt_nxt     = r_cnt;
      w_reload_nxt  = r_reload;
      w_mode_nxt    = r_mode;
      w_expired_nxt = 1'b0;
      if (i_stop) begin
         w_cnt_nxt  = '0;
         w_mode_nxt = MODE_ONESHOT;
      end else if (i_load) begin
         // A load at count 1 pre-empts the terminal count, so no pulse here
         w_cnt_nxt    = i_cycles;
         w_reload_nxt = i_cycles;
         w_mode_nxt   = i_periodic ? MODE_PERIODIC : MODE_ONESHOT;
      end else if (r_cnt == WIDTH'(1)) begin
         w_expired_nxt = 1'b1;
         w_cnt_nxt     = (r_mode == MODE_PERIODIC) ? r_reload : '0;
      end else if (r_cnt != '0) begin
         w_cnt_nxt = r_cnt - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_reload  <= '0;
         r_mode    <= MODE_ONESHOT;
         r_expired <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_reload  <= w_reload_nxt;
         r_mode    <= w_mode_nxt;
         r_expired <= w_expired_nxt;
      end
   end

   assign o_busy    = (r_cnt != '0);
   assign o_expired = r_expired;

`ifdef FORMAL
   logic r_f_past;

   always_ff @(posedge clk) begin
      if (!reset_n) r_f_past <= 1'b0;
      else          r_f_past <= 1'b1;
   end

   always_comb assert (o_busy == (r_cnt != '0));

   a_load: assert property (@(posedge clk) disable iff (!reset_n)
      (i_load && !i_stop) |=> (r_cnt == $past(i_cycles)) && (r_reload == $past(i_cycles)));

   a_dec: assert property (@(posedge clk) disable iff (!reset_n)
      (!i_load && !i_stop && (r_cnt > WIDTH'(1))) |=> (r_cnt == $past(r_cnt) - WIDTH'(1)));

   a_exp: assert property (@(posedge clk) disable iff (!reset_n)
      (r_f_past && o_expired) |-> ($past(r_cnt) == WIDTH'(1)));
`endif

endmodule

// File: rtl/multi_timer.sv
// Array of independent countdown timers: decodes the single load request,
// fans out the stop mask and reduces busy into any_busy.
module multi_timer
   import timer_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int CH_W     = ch_idx_w(CHANNELS)
) (
   input  logic         clk,
   input  logic         reset_n,
   multi_timer_if.slave bus
);

   logic [CHANNELS-1:0] w_load_vec;
   logic [CHANNELS-1:0] w_busy;
   logic [CHANNELS-1:0] w_expired;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      // Indices >= CHANNELS match no channel, so such loads fall away
      assign w_load_vec[g] = bus.load && (32'(bus.load_ch) == g);

      timer_channel #(
         .WIDTH(WIDTH)
      ) u_ch (
         .clk       (clk),
         .reset_n   (reset_n),
         .i_load    (w_load_vec[g]),
         .i_cycles  (bus.load_cycles),
         .i_periodic(bus.load_periodic),
         .i_stop    (bus.stop[g]),
         .o_busy    (w_busy[g]),
         .o_expired (w_expired[g])
      );
   end

   assign bus.busy     = w_busy;
   assign bus.expired  = w_expired;
   assign bus.any_busy = |w_busy;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: each driven cycle queues the expected
// busy/expired/any_busy, a monitor pops and compares one entry per edge.
module tb_multi_timer;

   localparam int WIDTH    = 16;
   localparam int CHANNELS = 4;
   localparam int CH_W     = 3;

   typedef struct {
      string    tag;
      logic [3:0] busy;
      logic [3:0] expired;
   } sb_t;

   logic clk;
   logic reset_n;
   sb_t  sb_q[$];
   int   n_checks;
   int   n_errors;

   multi_timer_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W)) bus ();

   multi_timer #(
      .WIDTH   (WIDTH),
      .CHANNELS(CHANNELS),
      .CH_W    (CH_W)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask

   // Expected state after the coming edge, then release one-shot inputs
   task automatic tick(input string tag, input logic [3:0] eb, input logic [3:0] ee);
      sb_t e;
      e.tag     = tag;
      e.busy    = eb;
      e.expired = ee;
      sb_q.push_back(e);
      @(posedge clk);
      #2;
      bus.load = 1'b0;
      bus.stop = '0;
   endtask

   task automatic set_load(input int ch, input int cycles, input logic periodic);
      bus.load          = 1'b1;
      bus.load_ch       = CH_W'(ch);
      bus.load_cycles   = WIDTH'(cycles);
      bus.load_periodic = periodic;
   endtask

   initial begin
      sb_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, "_busy"},    32'(bus.busy),     32'(e.busy));
            check({e.tag, "_expired"}, 32'(bus.expired),  32'(e.expired));
            check({e.tag, "_any"},     32'(bus.any_busy), 32'(|e.busy));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks          = 0;
      n_errors          = 0;
      reset_n           = 1'b0;
      bus.load          = 1'b0;
      bus.load_ch       = '0;
      bus.load_cycles   = '0;
      bus.load_periodic = 1'b0;
      bus.stop          = '0;
      tick("reset0", 4'b0000, 4'b0000);
      tick("reset1", 4'b0000, 4'b0000);
      reset_n = 1'b1;
      tick("idle", 4'b0000, 4'b0000);

      // One-shot 5 on ch0: busy for 5 cycles, then a single pulse
      set_load(0, 5, 1'b0);
      tick("os_load", 4'b0001, 4'b0000);
      for (int k = 0; k < 4; k++) tick("os_run", 4'b0001, 4'b0000);
      tick("os_exp", 4'b0000, 4'b0001);
      tick("os_after", 4'b0000, 4'b0000);

      // Periodic 3 on ch1: pulse every third cycle, busy never drops
      set_load(1, 3, 1'b1);
      tick("per_load", 4'b0010, 4'b0000);
      for (int t = 1; t <= 10; t++)
         tick("per_run", 4'b0010, ((t % 3) == 0) ? 4'b0010 : 4'b0000);
      bus.stop = 4'b0010;
      tick("per_stop", 4'b0000, 4'b0000);

      // Reload ch2 mid-count: first load never expires
      set_load(2, 8, 1'b0);
      tick("rl_load", 4'b0100, 4'b0000);
      for (int k = 0; k < 4; k++) tick("rl_run", 4'b0100, 4'b0000);
      set_load(2, 2, 1'b0);
      tick("rl_reload", 4'b0100, 4'b0000);
      tick("rl_cnt1", 4'b0100, 4'b0000);
      tick("rl_exp", 4'b0000, 4'b0100);
      tick("rl_after", 4'b0000, 4'b0000);

      // Stop beats a simultaneous load
      set_load(3, 4, 1'b1);
      tick("sl_load", 4'b1000, 4'b0000);
      tick("sl_run", 4'b1000, 4'b0000);
      set_load(3, 4, 1'b1);
      bus.stop = 4'b1000;
      tick("sl_stop", 4'b0000, 4'b0000);
      tick("sl_after", 4'b0000, 4'b0000);

      // Load 1, load 0, then an out-of-range index
      set_load(0, 1, 1'b0);
      tick("z_load1", 4'b0001, 4'b0000);
      set_load(1, 0, 1'b0);
      tick("z_load0", 4'b0000, 4'b0001);
      set_load(7, 5, 1'b1);
      tick("z_bad_idx", 4'b0000, 4'b0000);
      tick("z_after", 4'b0000, 4'b0000);

      // Two channels overlapping, then a load landing on count 1
      set_load(0, 2, 1'b1);
      tick("ind_ld0", 4'b0001, 4'b0000);
      set_load(3, 3, 1'b0);
      tick("ind_ld3", 4'b1001, 4'b0000);
      tick("ind_c0exp", 4'b1001, 4'b0001);
      tick("ind_both1", 4'b1001, 4'b0000);
      tick("ind_both_exp", 4'b0001, 4'b1001);
      tick("ind_c0_1", 4'b0001, 4'b0000);
      set_load(0, 3, 1'b0);
      tick("ld_at_one", 4'b0001, 4'b0000);
      bus.stop = 4'b1111;
      tick("stop_all", 4'b0000, 4'b0000);

      // Reset mid-count at count 2, with a load pending on the same edge
      set_load(0, 4, 1'b0);
      tick("rm_load", 4'b0001, 4'b0000);
      tick("rm_c3", 4'b0001, 4'b0000);
      tick("rm_c2", 4'b0001, 4'b0000);
      reset_n = 1'b0;
      set_load(1, 5, 1'b0);
      tick("rm_reset", 4'b0000, 4'b0000);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) tick("rm_post", 4'b0000, 4'b0000);

      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter WIDTH, default 16: counter and cycles width in bits, legal range 2..32.
REQ-002 Parameter CHANNELS, default 4: number of independent countdown channels, legal range 1..16.
REQ-003 Parameter CH_W, default $clog2(CHANNELS) with a minimum of 1: channel index width.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  synchronous active-low reset.
REQ-007 load  input  1  request to load one channel this cycle.
REQ-008 load_ch  input  CH_W  channel targeted by load; values >= CHANNELS are ignored.
REQ-009 load_cycles  input  WIDTH  count value for the loaded channel.
REQ-010 load_periodic  input  1  mode for the loaded channel: 1 = periodic, 0 = one-shot.
REQ-011 stop  input  CHANNELS  per-channel abort, bit i aborts channel i.
REQ-012 busy  output  CHANNELS  bit i high while counter[i] > 0 (combinational from the counter).
REQ-013 expired  output  CHANNELS  registered one-cycle pulse on terminal count of channel i.
REQ-014 any_busy  output  1  OR of all busy bits.

Function
REQ-015 Each channel SHALL hold a WIDTH-bit counter, a WIDTH-bit reload register and a mode bit.
REQ-016 A load to a valid channel i SHALL set counter[i] = load_cycles, reload[i] = load_cycles and mode[i] = load_periodic on the next edge (1-cycle latency).
REQ-017 A load while channel i is busy SHALL restart it with the new value, with no expired pulse.
REQ-018 A load with load_cycles == 0 SHALL leave channel i idle (counter 0), with no expired pulse.
REQ-019 An idle, unloaded channel SHALL hold counter 0 and SHALL NOT pulse expired.
REQ-020 If busy and not loaded or stopped, counter[i] SHALL decrement by 1 each cycle.
REQ-021 One-shot terminal count: at counter 1, next edge counter becomes 0 and expired[i] = 1 for that one cycle.
REQ-022 Periodic terminal count: at counter 1, next edge counter = reload[i] and expired[i] = 1 for one cycle; busy stays high (period = reload cycles).
REQ-023 Terminal counts SHALL never produce wrap-around to 2^WIDTH-1; counter never decrements from 0.
REQ-024 stop[i] SHALL clear counter[i] to 0 and the mode bit on the next edge, with no expired pulse.
REQ-025 stop[i] and a load to channel i in the same cycle: stop wins.
REQ-026 A load to channel i in the cycle counter[i] == 1: load wins, no expired pulse.
REQ-027 Channels SHALL be fully independent; only one channel can be loaded per cycle, and any stop mask is legal.

Reset
REQ-028 reset_n low at an edge SHALL clear all counters, reload registers, mode bits and expired bits.
REQ-029 After reset, busy, expired and any_busy SHALL all read 0; reset overrides load and stop.
REQ-030 Reset mid-count SHALL abort silently, with no expired pulse in the cycle after reset.

Structure
REQ-031 Package timer_pkg SHALL hold the mode encoding (MODE_ONESHOT = 0, MODE_PERIODIC = 1) and the default WIDTH/CHANNELS constants.
REQ-032 Per-channel logic SHALL live in sub-module timer_channel (WIDTH parameter), instantiated CHANNELS times by a generate loop.
REQ-033 The top level SHALL contain only load decode, the stop fan-out and the any_busy reduction.
REQ-034 Formal properties SHALL be guarded by FORMAL: busy == (counter != 0), the load result, decrement by exactly 1, and expired only following counter == 1.

Verification
REQ-035 Reset, then one-shot load ch0 with 5 -> busy[0] high for exactly 5 cycles; expired[0] pulses once, on the edge where the counter reaches 0.
REQ-036 Periodic load ch1 with 3, run 10 cycles -> expired[1] pulses every 3 cycles; busy[1] stays continuously high.
REQ-037 Load ch2 with 8; at counter 4 reload with 2 -> counter 2 next cycle; single expired 2 cycles later, no pulse for the first load.
REQ-038 Periodic ch3 with 4; assert stop[3] and a load to ch3 in the same cycle -> counter 0, busy[3] low, no expired.
REQ-039 Load ch0 with 1 and ch1 with 0; load_ch = 7 with CHANNELS = 4 -> ch0 expires after 1 cycle, ch1 stays idle, no channel changes on the invalid index.
REQ-040 Drop reset_n low while ch0 is at count 2 -> all outputs 0 next cycle; no expired pulse afterwards.
